// File: rtl/int_gateway.sv
// rtl/int_gateway.sv - peripheral interrupt gateway: pending latch, enable mask, clear, missed-event counters
module int_gateway #(
    parameter int                  INT_BITS   = 4,
    parameter int                  CNT_BITS   = 4,
    parameter logic [INT_BITS-1:0] LEVEL_MASK = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INT_BITS-1:0] src_i,
    input  logic                reg_sel_i,
    input  logic                reg_we_i,
    input  logic [3:0]          reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic [31:0]         reg_rdata_o,
    output logic                reg_rvalid_o,
    output logic [INT_BITS-1:0] interrupt_o
);

    localparam int MW = INT_BITS * CNT_BITS;

    logic [INT_BITS-1:0] pending;
    logic [INT_BITS-1:0] pending_nxt;
    logic [INT_BITS-1:0] enable;
    logic [INT_BITS-1:0] src_d;
    logic [INT_BITS-1:0] rise;
    logic [INT_BITS-1:0] clr_vec;
    logic [MW-1:0]       missed;
    logic [MW-1:0]       missed_nxt;
    logic [CNT_BITS-1:0] cnt;
    logic [1:0]          word;
    logic                wr;
    logic                rd;
    logic [31:0]         rd_mux;
    logic                unused_bits;

    assign word        = reg_addr_i[3:2];
    assign wr          = reg_sel_i & reg_we_i;
    assign rd          = reg_sel_i & ~reg_we_i;
    assign rise        = src_i & ~src_d;
    assign clr_vec     = (wr && word == 2'd2) ? reg_wdata_i[INT_BITS-1:0] : '0;
    assign interrupt_o = pending & enable;
    assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i[31:INT_BITS]};

    // Per-source next state: a new rising edge beats a simultaneous clear
    always_comb begin
        pending_nxt = pending;
        missed_nxt  = missed;
        cnt         = '0;
        for (int i = 0; i < INT_BITS; i++) begin
            cnt = missed[i*CNT_BITS +: CNT_BITS];
            if (LEVEL_MASK[i]) begin
                pending_nxt[i]                  = src_i[i];
                missed_nxt[i*CNT_BITS +: CNT_BITS] = '0;
            end else if (rise[i] && clr_vec[i]) begin
                pending_nxt[i]                  = 1'b1;
                missed_nxt[i*CNT_BITS +: CNT_BITS] = '0;
            end else if (rise[i] && pending[i]) begin
                if (cnt != {CNT_BITS{1'b1}})
                    missed_nxt[i*CNT_BITS +: CNT_BITS] = cnt + CNT_BITS'(1);
            end else if (rise[i]) begin
                pending_nxt[i] = 1'b1;
            end else if (clr_vec[i]) begin
                pending_nxt[i]                  = 1'b0;
                missed_nxt[i*CNT_BITS +: CNT_BITS] = '0;
            end
        end
    end

    // Register read mux; unimplemented upper bits read as zero
    always_comb begin
        rd_mux = '0;
        case (word)
            2'd0:    rd_mux[INT_BITS-1:0] = pending;
            2'd1:    rd_mux[INT_BITS-1:0] = enable;
            2'd3:    rd_mux[MW-1:0]       = missed;
            default: rd_mux               = '0;
        endcase
    end

    // State update; reset wins over any access in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= '0;
            enable       <= '0;
            missed       <= '0;
            src_d        <= '0;
            reg_rdata_o  <= '0;
            reg_rvalid_o <= 1'b0;
        end else begin
            pending      <= pending_nxt;
            missed       <= missed_nxt;
            src_d        <= src_i;
            reg_rvalid_o <= rd;
            if (rd)
                reg_rdata_o <= rd_mux;
            if (wr && word == 2'd1)
                enable <= reg_wdata_i[INT_BITS-1:0];
        end
    end

endmodule

// File: tb/tb_int_gateway.sv
// tb/tb_int_gateway.sv - directed scoreboard bench for int_gateway
module tb_int_gateway;

    localparam logic [3:0] A_PEND = 4'h0;
    localparam logic [3:0] A_EN   = 4'h4;
    localparam logic [3:0] A_CLR  = 4'h8;
    localparam logic [3:0] A_MISS = 4'hC;

    logic        clk;
    logic        rst;
    logic [3:0]  src;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic [3:0]  irq;
    logic [31:0] lvl_rdata;
    logic        lvl_rvalid;
    logic [3:0]  lvl_irq;

    int total;
    int passed;

    logic [31:0] exp_q[$];
    logic [31:0] lvl_q[$];

    int_gateway #(.INT_BITS(4), .CNT_BITS(4), .LEVEL_MASK(4'b0000)) dut (
        .clk(clk), .rst(rst), .src_i(src),
        .reg_sel_i(sel), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_rdata_o(rdata), .reg_rvalid_o(rvalid), .interrupt_o(irq)
    );

    int_gateway #(.INT_BITS(4), .CNT_BITS(4), .LEVEL_MASK(4'b0100)) dut_lvl (
        .clk(clk), .rst(rst), .src_i(src),
        .reg_sel_i(sel), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_rdata_o(lvl_rdata), .reg_rvalid_o(lvl_rvalid), .interrupt_o(lvl_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    // Expected value enters the scoreboard with the strobe; popped on rvalid
    task automatic reg_read(input string tag, input logic [3:0] a, input logic [31:0] exp, input bit use_lvl);
        int k;
        logic        v;
        logic [31:0] d;
        logic [31:0] e;
        sel = 1'b1; we = 1'b0; addr = a;
        if (use_lvl) lvl_q.push_back(exp);
        else         exp_q.push_back(exp);
        tick();
        sel = 1'b0;
        k = 0;
        v = use_lvl ? lvl_rvalid : rvalid;
        while (!v && k < 4) begin
            tick();
            k++;
            v = use_lvl ? lvl_rvalid : rvalid;
        end
        chk({tag, "_rvalid"}, {31'd0, v}, 32'd1);
        d = use_lvl ? lvl_rdata : rdata;
        e = use_lvl ? lvl_q.pop_front() : exp_q.pop_front();
        chk(tag, d, e);
    endtask

    task automatic pulse(input int bitn);
        src[bitn] = 1'b1;
        tick();
        src[bitn] = 1'b0;
        tick();
    endtask

    initial begin
        total = 0; passed = 0;
        rst = 1'b1; src = '0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) tick();
        chk("rst_irq", {28'd0, irq}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();

        // edge source 2 raises the request until cleared
        reg_write(A_EN, 32'hFFFF_FFFF);
        reg_read("en_upper_zero", A_EN, 32'h0000_000F, 1'b0);
        src[2] = 1'b1;
        tick();
        src[2] = 1'b0;
        chk("irq_after_rise", {28'd0, irq}, 32'h4);
        repeat (3) tick();
        chk("irq_held", {28'd0, irq}, 32'h4);
        reg_read("pend_src2", A_PEND, 32'h4, 1'b0);
        reg_read("clr_reads_zero", A_CLR, 32'h0, 1'b0);
        reg_write(A_CLR, 32'h4);
        chk("irq_cleared", {28'd0, irq}, 32'h0);

        // masked source still latches; enabling exposes it the next cycle
        reg_write(A_EN, 32'h0);
        pulse(1);
        chk("irq_masked", {28'd0, irq}, 32'h0);
        reg_read("pend_masked", A_PEND, 32'h2, 1'b0);
        reg_write(A_EN, 32'h2);
        chk("irq_after_enable", {28'd0, irq}, 32'h2);

        // missed counter saturates for edge source 3
        pulse(3);
        for (int n = 0; n < 20; n++) pulse(3);
        reg_read("missed_sat", A_MISS, 32'h0000_F000, 1'b0);
        reg_write(A_CLR, 32'h8);
        reg_read("pend_after_clr3", A_PEND, 32'h2, 1'b0);
        reg_read("missed_after_clr3", A_MISS, 32'h0, 1'b0);

        // rise coincident with clear: event wins, counter resets
        pulse(0);
        pulse(0);
        reg_read("missed0_one", A_MISS, 32'h1, 1'b0);
        src[0] = 1'b1;
        reg_write(A_CLR, 32'h1);
        src[0] = 1'b0;
        tick();
        reg_read("pend_rise_clr", A_PEND, 32'h3, 1'b0);
        reg_read("missed_rise_clr", A_MISS, 32'h0, 1'b0);

        // level-mode source 2 on the second instance ignores CLEAR
        src[2] = 1'b1;
        tick();
        reg_read("lvl_pend_high", A_PEND, 32'h7, 1'b1);
        reg_write(A_CLR, 32'h4);
        reg_read("lvl_pend_after_clr", A_PEND, 32'h7, 1'b1);
        src[2] = 1'b0;
        tick();
        reg_read("lvl_pend_dropped", A_PEND, 32'h3, 1'b1);
        reg_read("lvl_missed", A_MISS, 32'h0, 1'b1);

        // source held through reset is seen as a rising edge afterwards
        src = 4'b0001;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        reg_read("pend_post_reset", A_PEND, 32'h1, 1'b0);
        reg_read("irq_post_reset_en", A_EN, 32'h0, 1'b0);

        // reset during a read strobe suppresses the response
        sel = 1'b1; we = 1'b0; addr = A_PEND; rst = 1'b1;
        tick();
        sel = 1'b0;
        chk("rst_mid_read_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_mid_read_rdata", rdata, 32'd0);
        src = '0;
        tick();
        rst = 1'b0;
        tick();
        reg_read("zero_pend", A_PEND, 32'h0, 1'b0);
        reg_read("zero_en", A_EN, 32'h0, 1'b0);
        reg_read("zero_clr", A_CLR, 32'h0, 1'b0);
        reg_read("zero_miss", A_MISS, 32'h0, 1'b0);
        chk("zero_irq", {28'd0, irq}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
